// File: rtl/hero_motion_ctrl.sv
// Hero position and bomb state, updated once per video frame, with one-frame collision rollback.
// Optional HERO_LIVES_EN adds death/lives/game_over handling; the default build omits those ports.
module hero_motion_ctrl #(
    parameter int START_X      = 320,
    parameter int START_Y      = 400,
    parameter int WALK_STEP    = 2,
    parameter int RISE_STEP    = 2,
    parameter int FALL_STEP    = 1,
    parameter int FUSE_FRAMES  = 30,
    parameter int BLAST_FRAMES = 15,
    parameter int BOMB_OFS_Y   = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_bomb,
    input  logic       coll,
`ifdef HERO_LIVES_EN
    input  logic       death,
    output logic [1:0] lives,
    output logic       game_over,
`endif
    output logic [9:0] char_pos_x,
    output logic [9:0] char_pos_y,
    output logic [9:0] bomb_pos_x,
    output logic [9:0] bomb_pos_y,
    output logic [3:0] b_cnt
);

    localparam int FUSE_W = $clog2((FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES);
    localparam logic [FUSE_W-1:0] FUSE_LAST  = FUSE_W'(FUSE_FRAMES - 1);
    localparam logic [FUSE_W-1:0] BLAST_LAST = FUSE_W'(BLAST_FRAMES - 1);
    localparam logic [9:0] START_X_V = 10'(START_X);
    localparam logic [9:0] START_Y_V = 10'(START_Y);
    localparam logic signed [11:0] WALK_S = 12'(WALK_STEP);
    localparam logic signed [11:0] RISE_S = 12'(RISE_STEP);
    localparam logic signed [11:0] FALL_S = 12'(FALL_STEP);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        MOVE    = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Index 0 is the x axis, index 1 the y axis.
    logic [9:0]        pos_reg  [2];
    logic [9:0]        prev_reg [2];
    logic [9:0]        sat_pos  [2];
    logic signed [11:0] delta   [2];

    logic              coll_seen_reg;
    logic              coll_hit_reg;
    logic              btn_bomb_d_reg;
    logic [9:0]        bomb_x_reg;
    logic [9:0]        bomb_y_reg;
    logic [3:0]        b_cnt_reg;
    logic [FUSE_W-1:0] fuse_cnt_reg;

    logic tick_ok;
    logic bomb_edge;
    logic death_evt;
    logic hold_pos;
    logic bomb_block;

    assign tick_ok   = frame_tick && (state_reg == IDLE);
    assign bomb_edge = btn_bomb && !btn_bomb_d_reg && !bomb_block;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (frame_tick) state_next = RESOLVE;
            RESOLVE: state_next = MOVE;
            MOVE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        delta[0] = 12'sd0;
        if (btn_left && !btn_right) begin
            delta[0] = -WALK_S;
        end else if (btn_right && !btn_left) begin
            delta[0] = WALK_S;
        end
        delta[1] = btn_up ? -RISE_S : FALL_S;
    end

    // Signed 12-bit candidate so a step past either edge clamps instead of wrapping.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic signed [11:0] AXIS_MAX = (gi == 0) ? 12'sd634 : 12'sd474;
            logic signed [11:0] cand;
            assign cand = $signed({2'b00, pos_reg[gi]}) + delta[gi];
            assign sat_pos[gi] = (cand < 12'sd1)    ? 10'd1 :
                                 (cand > AXIS_MAX) ? AXIS_MAX[9:0] : cand[9:0];
        end
    endgenerate

    // The tick snapshots the frame's collision history before clearing it for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            coll_seen_reg <= 1'b0;
            coll_hit_reg  <= 1'b0;
        end else if (tick_ok) begin
            coll_seen_reg <= 1'b0;
            coll_hit_reg  <= coll_seen_reg;
        end else begin
            coll_seen_reg <= coll_seen_reg | coll;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_reg[0]  <= START_X_V;
            pos_reg[1]  <= START_Y_V;
            prev_reg[0] <= START_X_V;
            prev_reg[1] <= START_Y_V;
        end else if (death_evt) begin
            pos_reg[0]  <= START_X_V;
            pos_reg[1]  <= START_Y_V;
            prev_reg[0] <= START_X_V;
            prev_reg[1] <= START_Y_V;
        end else if (!hold_pos) begin
            for (int i = 0; i < 2; i++) begin
                if (state_reg == RESOLVE) begin
                    if (coll_hit_reg) begin
                        pos_reg[i] <= prev_reg[i];
                    end else begin
                        prev_reg[i] <= pos_reg[i];
                    end
                end else if (state_reg == MOVE) begin
                    prev_reg[i] <= pos_reg[i];
                    pos_reg[i]  <= sat_pos[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_bomb_d_reg <= 1'b0;
            bomb_x_reg     <= 10'd0;
            bomb_y_reg     <= 10'd0;
            b_cnt_reg      <= 4'd0;
            fuse_cnt_reg   <= '0;
        end else begin
            btn_bomb_d_reg <= btn_bomb;
            if (death_evt) begin
                b_cnt_reg    <= 4'd0;
                fuse_cnt_reg <= '0;
            end else if (bomb_edge && (b_cnt_reg == 4'd0)) begin
                // Position sampled here is pre-RESOLVE even when the tick lands in this cycle.
                bomb_x_reg   <= pos_reg[0];
                bomb_y_reg   <= pos_reg[1] + 10'(BOMB_OFS_Y);
                b_cnt_reg    <= 4'd1;
                fuse_cnt_reg <= '0;
            end else if (tick_ok && (b_cnt_reg != 4'd0)) begin
                if (fuse_cnt_reg == ((b_cnt_reg == 4'd3) ? BLAST_LAST : FUSE_LAST)) begin
                    fuse_cnt_reg <= '0;
                    b_cnt_reg    <= (b_cnt_reg == 4'd3) ? 4'd0 : b_cnt_reg + 4'd1;
                end else begin
                    fuse_cnt_reg <= fuse_cnt_reg + 1'b1;
                end
            end
        end
    end

`ifdef HERO_LIVES_EN
    logic [1:0] lives_reg;
    logic       game_over_reg;
    logic       skip_reg;

    // skip_reg suppresses the RESOLVE/MOVE pair that follows a death tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            lives_reg     <= 2'd3;
            game_over_reg <= 1'b0;
            skip_reg      <= 1'b0;
        end else begin
            if (tick_ok) begin
                skip_reg <= death_evt;
            end
            if (death_evt) begin
                lives_reg <= lives_reg - 2'd1;
                if (lives_reg == 2'd1) begin
                    game_over_reg <= 1'b1;
                end
            end
        end
    end

    assign death_evt  = tick_ok && death && !game_over_reg;
    assign hold_pos   = skip_reg || game_over_reg;
    assign bomb_block = game_over_reg;
    assign lives      = lives_reg;
    assign game_over  = game_over_reg;
`else
    assign death_evt  = 1'b0;
    assign hold_pos   = 1'b0;
    assign bomb_block = 1'b0;
`endif

    assign char_pos_x = pos_reg[0];
    assign char_pos_y = pos_reg[1];
    assign bomb_pos_x = bomb_x_reg;
    assign bomb_pos_y = bomb_y_reg;
    assign b_cnt      = b_cnt_reg;

endmodule

// File: tb/tb_hero_motion_ctrl.sv
// Bench for hero_motion_ctrl: directed scenarios plus randomized frames against a frame-level model.
module tb_hero_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_bomb = 1'b0;
    logic       coll = 1'b0;
    logic [9:0] char_pos_x, char_pos_y, bomb_pos_x, bomb_pos_y;
    logic [3:0] b_cnt;
`ifdef HERO_LIVES_EN
    logic       death = 1'b0;
    logic [1:0] lives;
    logic       game_over;
`endif

    int checks = 0;
    int failures = 0;

    // Frame-level reference model state.
    int mx, my, mpx, mpy, mbx, mby, mb, mfuse;
    bit mpend;

    hero_motion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_up     (btn_up),
        .btn_bomb   (btn_bomb),
        .coll       (coll),
`ifdef HERO_LIVES_EN
        .death      (death),
        .lives      (lives),
        .game_over  (game_over),
`endif
        .char_pos_x (char_pos_x),
        .char_pos_y (char_pos_y),
        .bomb_pos_x (bomb_pos_x),
        .bomb_pos_y (bomb_pos_y),
        .b_cnt      (b_cnt)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic void model_reset();
        mx = 320; my = 400; mpx = 320; mpy = 400;
        mbx = 0; mby = 0; mb = 0; mfuse = 0; mpend = 0;
    endfunction

    // One frame: undo last move if a collision was reported, then apply this frame's move.
    function automatic void model_tick();
        int dx;
        if (mpend) begin
            mx = mpx; my = mpy;
        end
        mpend = 0;
        mpx = mx; mpy = my;
        dx = (btn_left && !btn_right) ? -2 : ((btn_right && !btn_left) ? 2 : 0);
        mx = clamp(mx + dx, 1, 634);
        my = clamp(my + (btn_up ? -2 : 1), 1, 474);
        if (mb != 0) begin
            mfuse++;
            if (mb < 3 && mfuse == 30) begin
                mb++; mfuse = 0;
            end else if (mb == 3 && mfuse == 15) begin
                mb = 0; mfuse = 0;
            end
        end
    endfunction

    function automatic void model_press();
        if (mb == 0) begin
            mbx = mx; mby = my + 18; mb = 1; mfuse = 0;
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Called at a negedge; returns at the negedge after the MOVE cycle.
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic press();
        btn_bomb = 1'b1;
        @(negedge clk);
        btn_bomb = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({char_pos_x, char_pos_y, bomb_pos_x, bomb_pos_y, b_cnt} !==
            {10'd320, 10'd400, 10'd0, 10'd0, 4'd0}) begin
            failures++;
            $display("FAIL reset: got pos=(%0d,%0d) bomb=(%0d,%0d) b_cnt=%0d, want (320,400) (0,0) 0",
                     char_pos_x, char_pos_y, bomb_pos_x, bomb_pos_y, b_cnt);
        end
    endtask

    task automatic test_walk();
        do_reset();
        btn_right = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (char_pos_x !== 10'(320 + 2 * i) || char_pos_y !== 10'(400 + i)) begin
                failures++;
                $display("FAIL walk tick %0d: got (%0d,%0d), want (%0d,%0d)",
                         i, char_pos_x, char_pos_y, 320 + 2 * i, 400 + i);
            end
        end
        btn_right = 1'b0;
    endtask

    task automatic test_collision();
        do_reset();
        btn_left = 1'b1;
        tick();
        checks++;
        if (char_pos_x !== 10'd318) begin
            failures++;
            $display("FAIL coll first step: got x=%0d, want 318", char_pos_x);
        end
        coll = 1'b1;
        @(negedge clk);
        coll = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        checks++;
        if (char_pos_x !== 10'd320 || char_pos_y !== 10'd400) begin
            failures++;
            $display("FAIL coll restore: got (%0d,%0d), want (320,400)", char_pos_x, char_pos_y);
        end
        @(negedge clk);
        checks++;
        if (char_pos_x !== 10'd318 || char_pos_y !== 10'd401) begin
            failures++;
            $display("FAIL coll restep: got (%0d,%0d), want (318,401)", char_pos_x, char_pos_y);
        end
        btn_left = 1'b0;
    endtask

    task automatic test_bomb();
        int exp_b;
        do_reset();
        press();
        checks++;
        if ({bomb_pos_x, bomb_pos_y, b_cnt} !== {10'd320, 10'd418, 4'd1}) begin
            failures++;
            $display("FAIL bomb drop: got (%0d,%0d) b_cnt=%0d, want (320,418) 1",
                     bomb_pos_x, bomb_pos_y, b_cnt);
        end
        for (int t = 1; t <= 75; t++) begin
            if (t == 10) press();
            tick();
            exp_b = (t < 30) ? 1 : ((t < 60) ? 2 : ((t < 75) ? 3 : 0));
            checks++;
            if (b_cnt !== 4'(exp_b) || bomb_pos_x !== 10'd320 || bomb_pos_y !== 10'd418) begin
                failures++;
                $display("FAIL bomb phase tick %0d: got b_cnt=%0d bomb=(%0d,%0d), want %0d (320,418)",
                         t, b_cnt, bomb_pos_x, bomb_pos_y, exp_b);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        btn_up = 1'b1;
        btn_right = 1'b1;
        for (int t = 1; t <= 199; t++) tick();
        checks++;
        if (char_pos_x !== 10'd634 || char_pos_y !== 10'd2) begin
            failures++;
            $display("FAIL sat approach: got (%0d,%0d), want (634,2)", char_pos_x, char_pos_y);
        end
        for (int t = 1; t <= 2; t++) begin
            tick();
            checks++;
            if (char_pos_x !== 10'd634 || char_pos_y !== 10'd1) begin
                failures++;
                $display("FAIL sat edge tick %0d: got (%0d,%0d), want (634,1)", t, char_pos_x, char_pos_y);
            end
        end
        btn_up = 1'b0;
        btn_right = 1'b0;
    endtask

    task automatic test_coincident_and_reset();
        do_reset();
        btn_right = 1'b1;
        tick();
        frame_tick = 1'b1;
        btn_bomb = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        btn_bomb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bomb_pos_x, bomb_pos_y, b_cnt, char_pos_x} !== {10'd322, 10'd419, 4'd1, 10'd324}) begin
            failures++;
            $display("FAIL coincident: got bomb=(%0d,%0d) b_cnt=%0d x=%0d, want (322,419) 1 324",
                     bomb_pos_x, bomb_pos_y, b_cnt, char_pos_x);
        end
        btn_right = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (t >= 29) begin
                checks++;
                if (b_cnt !== ((t == 30) ? 4'd2 : 4'd1)) begin
                    failures++;
                    $display("FAIL coincident fuse tick %0d: got b_cnt=%0d, want %0d",
                             t, b_cnt, (t == 30) ? 2 : 1);
                end
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks++;
        if ({b_cnt, char_pos_x, char_pos_y} !== {4'd0, 10'd320, 10'd400}) begin
            failures++;
            $display("FAIL reset mid-fuse: got b_cnt=%0d pos=(%0d,%0d), want 0 (320,400)",
                     b_cnt, char_pos_x, char_pos_y);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 150; f++) begin
            btn_left  = 1'($urandom_range(0, 1));
            btn_right = 1'($urandom_range(0, 1));
            btn_up    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                press();
                model_press();
            end
            if ($urandom_range(0, 2) == 0) begin
                coll = 1'b1;
                @(negedge clk);
                coll = 1'b0;
                mpend = 1;
            end
            tick();
            model_tick();
            checks++;
            if ({char_pos_x, char_pos_y, bomb_pos_x, bomb_pos_y, b_cnt} !==
                {10'(mx), 10'(my), 10'(mbx), 10'(mby), 4'(mb)}) begin
                failures++;
                $display("FAIL random frame %0d: got pos=(%0d,%0d) bomb=(%0d,%0d) b=%0d, want pos=(%0d,%0d) bomb=(%0d,%0d) b=%0d",
                         f, char_pos_x, char_pos_y, bomb_pos_x, bomb_pos_y, b_cnt, mx, my, mbx, mby, mb);
            end
        end
        btn_left = 1'b0;
        btn_right = 1'b0;
        btn_up = 1'b0;
    endtask

`ifdef HERO_LIVES_EN
    task automatic test_lives();
        do_reset();
        btn_right = 1'b1;
        death = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (lives !== 2'(3 - i) || char_pos_x !== 10'd320 || char_pos_y !== 10'd400) begin
                failures++;
                $display("FAIL lives death %0d: got lives=%0d pos=(%0d,%0d), want %0d (320,400)",
                         i, lives, char_pos_x, char_pos_y, 3 - i);
            end
        end
        death = 1'b0;
        tick();
        checks++;
        if (game_over !== 1'b1 || char_pos_x !== 10'd320 || char_pos_y !== 10'd400) begin
            failures++;
            $display("FAIL game over: got go=%0d pos=(%0d,%0d), want 1 (320,400)",
                     game_over, char_pos_x, char_pos_y);
        end
        btn_right = 1'b0;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_walk();
        test_collision();
        test_bomb();
        test_saturation();
        test_coincident_and_reset();
        test_random();
`ifdef HERO_LIVES_EN
        test_lives();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
